bus_rr_arbiter: RTL and testbench

Round-robin arbiter and transfer sequencer for the shared packet bus between `drvrs` device FIFOs. It watches each device's pending flag and grants one device at a time. For the granted device it pops the head packet, decodes the 8-bit destination field, and pushes the packet into the addressed device's input FIFO, or into every other device on broadcast. It sits between the per-device FIFO pairs and is the only master of the `pop`/`push` strobes on the bus.

---
 rtl/bus_rr_arbiter.sv | 153 +++++++++++++++
 tb/tb_bus_rr_arbiter.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
// rtl/bus_rr_arbiter.sv - round-robin arbiter and packet transfer sequencer for the shared device bus
// Optional feature macro: ARB_BURST_EN (multi-packet grants up to max_burst packets).
// Without the macro every grant moves exactly one packet.
module bus_rr_arbiter #(
  parameter int          drvrs     = 4,
  parameter int          pckg_sz   = 16,
  parameter logic [7:0]  broadcast = 8'hFF,
  parameter int          max_burst = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [drvrs-1:0]   pndng,
  input  logic [pckg_sz-1:0] D_pop [drvrs],
  input  logic [drvrs-1:0]   full,
  output logic [drvrs-1:0]   pop,
  output logic [drvrs-1:0]   push,
  output logic [pckg_sz-1:0] D_push,
  output logic [drvrs-1:0]   gnt,
  output logic               busy,
  output logic               drop
);

  localparam int               IW   = (drvrs > 1) ? $clog2(drvrs) : 1;
  localparam logic [drvrs-1:0] ONE  = drvrs'(1);
  localparam logic [8:0]       DRV9 = 9'(drvrs);
`ifdef ARB_BURST_EN
  localparam logic [3:0]       BURST_LIM = 4'(max_burst);
`endif

  typedef enum logic [1:0] {IDLE, POP, XFER} state_t;

  state_t             state, state_n;
  logic [IW-1:0]      last, last_n;
  logic [IW-1:0]      src, src_n;
  logic [IW-1:0]      pick, idx_c;
  logic [pckg_sz-1:0] pkt, pkt_n;
  logic [3:0]         cnt, cnt_n, cnt_inc;
  logic [drvrs-1:0]   gnt_n, mask, src_hot;
  logic [7:0]         dst;
  logic               found, valid, blocked, cont;
`ifdef ARB_BURST_EN
  logic [3:0]         cnt_after;
`endif

  // Round-robin search: first pending device strictly after the last one served.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx_c = '0;
    for (int k = 1; k <= drvrs; k++) begin
      idx_c = IW'((int'(last) + k) % drvrs);
      if (!found && pndng[idx_c]) begin
        found = 1'b1;
        pick  = idx_c;
      end
    end
  end

  // Destination decode of the latched packet into a target mask and blocking status.
  always_comb begin
    dst     = pkt[pckg_sz-1 -: 8];
    src_hot = ONE << src;
    mask    = '0;
    valid   = 1'b0;
    if (dst == broadcast) begin
      mask  = ~src_hot;
      valid = 1'b1;
    end else if ({1'b0, dst} < DRV9) begin
      mask  = ONE << dst;
      valid = 1'b1;
    end
    blocked = |(mask & full);
    cnt_inc = (cnt == 4'd15) ? cnt : cnt + 4'd1;
  end

  // Burst continuation decision, made with the count that includes the packet just moved.
  always_comb begin
    cont = 1'b0;
`ifdef ARB_BURST_EN
    cnt_after = valid ? cnt_inc : cnt;
    cont      = pndng[src] && (cnt_after < BURST_LIM);
`endif
  end

  // Next-state and strobe decode; push is the only output gated combinationally by full.
  always_comb begin
    state_n = state;
    last_n  = last;
    src_n   = src;
    pkt_n   = pkt;
    cnt_n   = cnt;
    gnt_n   = gnt;
    pop     = '0;
    push    = '0;
    drop    = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          src_n   = pick;
          gnt_n   = ONE << pick;
          cnt_n   = '0;
          state_n = POP;
        end
      end
      POP: begin
        pop     = src_hot;
        pkt_n   = D_pop[src];
        state_n = XFER;
      end
      XFER: begin
        if (!valid || !blocked) begin
          if (!valid) begin
            drop = 1'b1;
          end else begin
            push  = mask;
            cnt_n = cnt_inc;
          end
          if (cont) begin
            state_n = POP;
          end else begin
            last_n  = src;
            gnt_n   = '0;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight packet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      last  <= IW'(drvrs - 1);
      src   <= '0;
      pkt   <= '0;
      cnt   <= '0;
      gnt   <= '0;
    end else begin
      state <= state_n;
      last  <= last_n;
      src   <= src_n;
      pkt   <= pkt_n;
      cnt   <= cnt_n;
      gnt   <= gnt_n;
    end
  end

  assign busy   = (state != IDLE);
  assign D_push = pkt;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb/tb_bus_rr_arbiter.sv - self-checking bench for bus_rr_arbiter with FIFO and transfer-order models
module tb_bus_rr_arbiter;

  localparam int N = 4;
`ifdef ARB_BURST_EN
  localparam int MAXB = 2;
`else
  localparam int MAXB = 4;
`endif

  typedef struct {
    int          src;
    logic [15:0] data;
    logic [3:0]  mask;
    bit          drp;
  } xfer_t;

  logic        clk;
  logic        reset;
  logic [3:0]  pndng;
  logic [15:0] d_pop [N];
  logic [3:0]  full;
  logic [3:0]  pop, push, gnt;
  logic [15:0] d_push;
  logic        busy, drop;

  logic [15:0] q [N][$];
  logic [3:0]  full_v;
  logic [3:0]  pop_seen;
  xfer_t       exp_q [$];
  int          errors;
  int          checks;
  int          cyc;

  bus_rr_arbiter #(
    .drvrs(N), .pckg_sz(16), .broadcast(8'hFF), .max_burst(MAXB)
  ) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop), .full(full),
    .pop(pop), .push(push), .D_push(d_push), .gnt(gnt), .busy(busy), .drop(drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of the device-FIFO model: apply last cycle's pops, drive inputs, stop at negedge.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (pop_seen[i] && q[i].size() > 0) void'(q[i].pop_front());
    for (int i = 0; i < N; i++) begin
      pndng[i] = (q[i].size() != 0);
      d_pop[i] = (q[i].size() != 0) ? q[i][0] : 16'h0000;
    end
    full = full_v;
    cyc++;
    @(negedge clk);
    pop_seen = pop;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < N; i++) q[i].delete();
    full_v   = '0;
    pop_seen = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  function automatic int hot2idx(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Packet-level reference: walk the loaded FIFOs grant by grant from the post-reset priority.
  task automatic build_expected();
    logic [15:0] mq [N][$];
    logic [15:0] p;
    logic [7:0]  d;
    xfer_t       e;
    int          lst, s, moved, c;
    bit          go, any;
    for (int i = 0; i < N; i++) mq[i] = q[i];
    exp_q.delete();
    lst = N - 1;
    any = 1'b1;
    while (any) begin
      any = 1'b0;
      for (int i = 0; i < N; i++) if (mq[i].size() > 0) any = 1'b1;
      if (any) begin
        s = -1;
        for (int k = 1; k <= N; k++) begin
          c = (lst + k) % N;
          if (s < 0 && mq[c].size() > 0) s = c;
        end
        moved = 0;
        go = 1'b1;
        while (go) begin
          p = mq[s].pop_front();
          d = p[15:8];
          e.src = s; e.data = p; e.drp = 1'b0; e.mask = '0;
          if (d == 8'hFF) e.mask = 4'hF & ~(4'b0001 << s);
          else if (d < 8'd4) e.mask = 4'b0001 << d;
          else e.drp = 1'b1;
          exp_q.push_back(e);
          if (!e.drp) moved++;
`ifdef ARB_BURST_EN
          go = (mq[s].size() > 0) && (moved < MAXB);
`else
          go = 1'b0;
`endif
        end
        lst = s;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    checks++;
    if ({pop, push, gnt, busy, drop} !== 14'd0) begin
      errors++;
      $display("FAIL reset_strobes got=%b want=0", {pop, push, gnt, busy, drop});
    end
    checks++;
    if (d_push !== 16'h0000) begin
      errors++;
      $display("FAIL reset_dpush got=%h want=0000", d_push);
    end
    reset = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy got=%b want=0", busy);
    end
  endtask

  task automatic test_unicast();
    do_reset();
    q[1].push_back(16'h02AB);
    step();
    step();
    checks++;
    if (pop !== 4'b0010 || gnt !== 4'b0010) begin
      errors++;
      $display("FAIL uni_pop pop=%b gnt=%b want=0010", pop, gnt);
    end
    step();
    checks++;
    if (push !== 4'b0100 || d_push !== 16'h02AB) begin
      errors++;
      $display("FAIL uni_push push=%b data=%h want=0100/02ab", push, d_push);
    end
    step();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || push !== 4'b0000) begin
      errors++;
      $display("FAIL uni_done gnt=%b busy=%b push=%b want=0", gnt, busy, push);
    end
  endtask

  task automatic test_broadcast();
    do_reset();
    q[2].push_back(16'hFF55);
    full_v = 4'b0001;
    step();
    step();
    checks++;
    if (pop !== 4'b0100) begin
      errors++;
      $display("FAIL bc_pop got=%b want=0100", pop);
    end
    for (int c = 2; c <= 4; c++) begin
      step();
      checks++;
      if (push !== 4'b0000) begin
        errors++;
        $display("FAIL bc_blocked cycle=%0d got=%b want=0000", c, push);
      end
    end
    full_v = 4'b0000;
    step();
    checks++;
    if (push !== 4'b1011 || d_push !== 16'hFF55) begin
      errors++;
      $display("FAIL bc_push push=%b data=%h want=1011/ff55", push, d_push);
    end
    step();
    checks++;
    if (push !== 4'b0000 || gnt !== 4'b0000) begin
      errors++;
      $display("FAIL bc_once push=%b gnt=%b want=0", push, gnt);
    end
  endtask

  task automatic test_invalid();
    do_reset();
    q[1].push_back(16'h0211);
    for (int c = 0; c < 4; c++) step();
    q[3].push_back(16'h0700);
    step();
    step();
    checks++;
    if (pop !== 4'b1000) begin
      errors++;
      $display("FAIL inv_pop got=%b want=1000", pop);
    end
    step();
    checks++;
    if (drop !== 1'b1 || push !== 4'b0000) begin
      errors++;
      $display("FAIL inv_drop drop=%b push=%b want=1/0000", drop, push);
    end
    step();
    checks++;
    if (drop !== 1'b0 || busy !== 1'b0 || gnt !== 4'b0000) begin
      errors++;
      $display("FAIL inv_idle drop=%b busy=%b gnt=%b want=0", drop, busy, gnt);
    end
    q[0].push_back(16'h0101);
    q[2].push_back(16'h0101);
    step();
    step();
    checks++;
    if (pop !== 4'b0001) begin
      errors++;
      $display("FAIL inv_last pop=%b want=0001", pop);
    end
    for (int c = 0; c < 8; c++) step();
  endtask

`ifndef ARB_BURST_EN
  task automatic test_fairness();
    int order [$];
    int want [8];
    int npush;
    want = '{0, 1, 2, 3, 0, 1, 2, 3};
    npush = 0;
    do_reset();
    for (int i = 0; i < N; i++) begin
      q[i].push_back({8'((i + 1) % N), 8'(8'h10 + i)});
      q[i].push_back({8'((i + 2) % N), 8'(8'h20 + i)});
    end
    for (int c = 0; c < 60; c++) begin
      step();
      if (pop !== 4'b0000) order.push_back(hot2idx(pop));
      if (push !== 4'b0000) npush++;
    end
    checks++;
    if (order.size() != 8 || npush != 8) begin
      errors++;
      $display("FAIL rr_count pops=%0d pushes=%0d want=8/8", order.size(), npush);
    end
    for (int k = 0; k < 8 && k < order.size(); k++) begin
      checks++;
      if (order[k] != want[k]) begin
        errors++;
        $display("FAIL rr_order slot=%0d got=%0d want=%0d", k, order[k], want[k]);
      end
    end
  endtask
`else
  task automatic test_burst();
    int order [$];
    int pcyc [$];
    int want [4];
    want = '{0, 0, 1, 0};
    do_reset();
    for (int k = 0; k < 3; k++) q[0].push_back({8'h02, 8'(k)});
    q[1].push_back(16'h0377);
    for (int c = 0; c < 40; c++) begin
      step();
      if (pop !== 4'b0000) order.push_back(hot2idx(pop));
      if (push !== 4'b0000) pcyc.push_back(cyc);
    end
    checks++;
    if (order.size() != 4 || pcyc.size() != 4) begin
      errors++;
      $display("FAIL burst_count pops=%0d pushes=%0d want=4/4", order.size(), pcyc.size());
    end
    for (int k = 0; k < 4 && k < order.size(); k++) begin
      checks++;
      if (order[k] != want[k]) begin
        errors++;
        $display("FAIL burst_order slot=%0d got=%0d want=%0d", k, order[k], want[k]);
      end
    end
    if (pcyc.size() >= 2) begin
      checks++;
      if (pcyc[1] - pcyc[0] != 2) begin
        errors++;
        $display("FAIL burst_gap got=%0d want=2", pcyc[1] - pcyc[0]);
      end
    end
  endtask
`endif

  task automatic test_reset_xfer();
    int npop, nbb;
    int first_pop;
    do_reset();
    q[2].push_back(16'h01CC);
    q[2].push_back(16'h01BB);
    full_v = 4'b0010;
    step();
    step();
    step();
    checks++;
    if (busy !== 1'b1 || push !== 4'b0000) begin
      errors++;
      $display("FAIL rx_blocked busy=%b push=%b want=1/0000", busy, push);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({pop, push, gnt, busy, drop} !== 14'd0 || d_push !== 16'h0000) begin
      errors++;
      $display("FAIL rx_async got=%b data=%h want=0", {pop, push, gnt, busy, drop}, d_push);
    end
    pop_seen = '0;
    step();
    step();
    reset = 1'b0;
    full_v = 4'b0000;
    npop = 0; nbb = 0; first_pop = -1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (pop !== 4'b0000) begin
        if (first_pop < 0) first_pop = hot2idx(pop);
        npop++;
      end
      if (push !== 4'b0000) begin
        checks++;
        if (d_push !== 16'h01BB || push !== 4'b0010) begin
          errors++;
          $display("FAIL rx_stale push=%b data=%h want=0010/01bb", push, d_push);
        end
        nbb++;
      end
    end
    checks++;
    if (first_pop != 2 || npop != 1 || nbb != 1) begin
      errors++;
      $display("FAIL rx_repop first=%0d pops=%0d pushes=%0d want=2/1/1", first_pop, npop, nbb);
    end
  endtask

  task automatic test_random();
    int pi, xi, r, depth;
    logic [7:0] d;
    logic [3:0] want_pop;
    for (int round = 0; round < 12; round++) begin
      do_reset();
      for (int i = 0; i < N; i++) begin
        depth = $urandom_range(0, 3);
        for (int k = 0; k < depth; k++) begin
          r = $urandom_range(0, 9);
          if (r < 6) d = 8'(r % 4);
          else if (r < 8) d = 8'hFF;
          else d = 8'($urandom_range(4, 254));
          q[i].push_back({d, 8'($urandom)});
        end
      end
      build_expected();
      pi = 0;
      xi = 0;
      for (int c = 0; c < 400; c++) begin
        if (pi == exp_q.size() && xi == exp_q.size() && c > 2 && busy === 1'b0) break;
        full_v = 4'($urandom) & 4'($urandom);
        step();
        if (pop !== 4'b0000) begin
          want_pop = (pi < exp_q.size()) ? (4'b0001 << exp_q[pi].src) : 4'b0000;
          checks++;
          if (pop !== want_pop || gnt !== pop) begin
            errors++;
            $display("FAIL rnd_pop round=%0d idx=%0d pop=%b gnt=%b want=%b", round, pi, pop, gnt, want_pop);
          end
          pi++;
        end
        if (push !== 4'b0000 || drop === 1'b1) begin
          checks++;
          if (xi >= exp_q.size()) begin
            errors++;
            $display("FAIL rnd_extra round=%0d push=%b drop=%b want=none", round, push, drop);
          end else if (drop !== exp_q[xi].drp ||
                       (!exp_q[xi].drp && (push !== exp_q[xi].mask || d_push !== exp_q[xi].data))) begin
            errors++;
            $display("FAIL rnd_xfer round=%0d idx=%0d push=%b drop=%b data=%h want=%b/%b/%h",
                     round, xi, push, drop, d_push, exp_q[xi].mask, exp_q[xi].drp, exp_q[xi].data);
          end
          checks++;
          if ((push & full) !== 4'b0000) begin
            errors++;
            $display("FAIL rnd_full round=%0d push=%b full=%b want=disjoint", round, push, full);
          end
          xi++;
        end
      end
      checks++;
      if (pi != exp_q.size() || xi != exp_q.size() || busy !== 1'b0) begin
        errors++;
        $display("FAIL rnd_done round=%0d pops=%0d xfers=%0d busy=%b want=%0d", round, pi, xi, busy, exp_q.size());
      end
    end
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    cyc      = 0;
    reset    = 1'b1;
    pndng    = '0;
    full     = '0;
    full_v   = '0;
    pop_seen = '0;
    for (int i = 0; i < N; i++) d_pop[i] = '0;
    test_reset();
    test_unicast();
    test_broadcast();
    test_invalid();
`ifndef ARB_BURST_EN
    test_fairness();
`else
    test_burst();
`endif
    test_reset_xfer();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
